// File: rtl/apb_tach_monitor.sv
// Multi-channel fan tachometer with per-channel stall thresholds, sticky alarms and a masked IRQ,
// exposed as 16-bit registers on a zero-wait-state APB completer port.
module apb_tach_monitor #(
    parameter int NUM_CHANNELS = 4,
    parameter int GATE_CYCLES  = 250000000,
    parameter int RPM_SCALE    = 30,
    parameter int SYNC_STAGES  = 3,
    parameter int ADDR_WIDTH   = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [15:0]             pwdata,
    output logic                    pready,
    output logic [15:0]             prdata,
    output logic                    pslverr,
    input  logic [NUM_CHANNELS-1:0] tach,
    output logic                    irq
);

    localparam int CW = $clog2(GATE_CYCLES);
    localparam int HW = ADDR_WIDTH - 1;

    generate
        if (NUM_CHANNELS < 1 || NUM_CHANNELS > 8) begin : g_bad_channels
            $error("apb_tach_monitor: NUM_CHANNELS must be in 1..8");
        end
        if (GATE_CYCLES < 16) begin : g_bad_gate
            $error("apb_tach_monitor: GATE_CYCLES must be >= 16");
        end
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("apb_tach_monitor: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    // Product is formed at 64 bits so a saturated 32-bit edge count cannot wrap before the clamp.
    function automatic logic [15:0] sat_rpm(input logic [31:0] count);
        logic [63:0] prod;
        prod = 64'(count) * 64'(RPM_SCALE);
        return (prod > 64'h0000_0000_0000_ffff) ? 16'hffff : prod[15:0];
    endfunction

    logic [NUM_CHANNELS-1:0] sync_p [SYNC_STAGES];
    logic [NUM_CHANNELS-1:0] tach_d;
    logic [NUM_CHANNELS-1:0] edge_det;

    logic [CW-1:0]           win_cnt;
    logic                    win_end;
    logic [31:0]             edges   [NUM_CHANNELS];
    logic [15:0]             rpm     [NUM_CHANNELS];
    logic [15:0]             min_rpm [NUM_CHANNELS];
    logic [15:0]             rpm_new [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] valid;
    logic [NUM_CHANNELS-1:0] alarm;
    logic [NUM_CHANNELS-1:0] alarm_set;
    logic [NUM_CHANNELS-1:0] irq_en;
    logic [NUM_CHANNELS-1:0] min_wr;
    logic [NUM_CHANNELS-1:0] w1c;

    logic [HW-1:0]           hw_addr;
    logic                    apb_acc;
    logic                    apb_wr;
    logic                    acc_err;
    logic                    sts_wr;
    logic                    ien_wr;
    logic [15:0]             rd_data;
    logic [7:0]              alarm_x;
    logic [7:0]              valid_x;
    logic [7:0]              ien_x;
    logic                    unused_addr_lsb;

    // Input synchroniser chain followed by the rising-edge detect flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
            tach_d <= '0;
        end else begin
            sync_p[0] <= tach;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            tach_d <= sync_p[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_p[SYNC_STAGES-1] & ~tach_d;
    assign win_end  = (win_cnt == CW'(GATE_CYCLES - 1));

    always_comb begin
        alarm_set = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            rpm_new[ch]   = sat_rpm(edges[ch]);
            alarm_set[ch] = win_end && (min_rpm[ch] != 16'd0) && (rpm_new[ch] < min_rpm[ch]);
        end
    end

    assign hw_addr         = paddr[ADDR_WIDTH-1:1];
    assign unused_addr_lsb = paddr[0];
    assign apb_acc         = psel & penable;
    assign apb_wr          = apb_acc & pwrite;

    // Halfword map: 0 STATUS, 1 IRQ_EN, 8+2*ch RPM, 9+2*ch MIN_RPM; everything else errors
    always_comb begin
        alarm_x = '0;
        valid_x = '0;
        ien_x   = '0;
        alarm_x[NUM_CHANNELS-1:0] = alarm;
        valid_x[NUM_CHANNELS-1:0] = valid;
        ien_x[NUM_CHANNELS-1:0]   = irq_en;
        rd_data = '0;
        acc_err = 1'b1;
        sts_wr  = 1'b0;
        ien_wr  = 1'b0;
        min_wr  = '0;
        if (hw_addr == HW'(0)) begin
            rd_data = {valid_x, alarm_x};
            acc_err = 1'b0;
            sts_wr  = apb_wr;
        end else if (hw_addr == HW'(1)) begin
            rd_data = {8'h00, ien_x};
            acc_err = 1'b0;
            ien_wr  = apb_wr;
        end
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (hw_addr == HW'(8 + 2 * ch)) begin
                rd_data = rpm[ch];
                acc_err = pwrite;
            end else if (hw_addr == HW'(9 + 2 * ch)) begin
                rd_data    = min_rpm[ch];
                acc_err    = 1'b0;
                min_wr[ch] = apb_wr;
            end
        end
    end

    assign w1c     = sts_wr ? pwdata[NUM_CHANNELS-1:0] : '0;
    assign pready  = apb_acc;
    assign prdata  = apb_acc ? rd_data : 16'h0000;
    assign pslverr = apb_acc & acc_err;

    // Window, measurement and register state; alarm set takes priority over a same-edge W1C
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
            valid   <= '0;
            alarm   <= '0;
            irq_en  <= '0;
            irq     <= 1'b0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                edges[ch]   <= '0;
                rpm[ch]     <= '0;
                min_rpm[ch] <= '0;
            end
        end else begin
            win_cnt <= win_end ? '0 : win_cnt + CW'(1);
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (win_end) begin
                    rpm[ch]   <= rpm_new[ch];
                    edges[ch] <= {31'd0, edge_det[ch]};
                end else if (edge_det[ch] && (edges[ch] != 32'hffff_ffff)) begin
                    edges[ch] <= edges[ch] + 32'd1;
                end
                if (min_wr[ch]) min_rpm[ch] <= pwdata;
            end
            if (win_end) valid <= '1;
            alarm <= (alarm & ~w1c) | alarm_set;
            if (ien_wr) irq_en <= pwdata[NUM_CHANNELS-1:0];
            irq <= |(alarm & irq_en);
        end
    end

endmodule

// File: tb/tb_apb_tach_monitor.sv
// Bench for apb_tach_monitor: two instances (RPM_SCALE 30 and 200) share the bus and tach inputs.
module tb_apb_tach_monitor;

    localparam int N    = 4;
    localparam int GATE = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [10:0] paddr = '0;
    logic [15:0] pwdata = '0;
    logic        pready, pslverr, irq;
    logic        pready_s, pslverr_s, irq_s;
    logic [15:0] prdata, prdata_s;
    logic [N-1:0] tach = '0;

    int errors = 0;
    int checks = 0;
    int since_rst;
    int cyc = 0;
    int tach_per [N];

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic        sel;
        string       name;
    } exp_t;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    apb_tach_monitor #(.NUM_CHANNELS(N), .GATE_CYCLES(GATE), .RPM_SCALE(30),
                       .SYNC_STAGES(3), .ADDR_WIDTH(11)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata),
        .pslverr(pslverr), .tach(tach), .irq(irq));

    apb_tach_monitor #(.NUM_CHANNELS(N), .GATE_CYCLES(GATE), .RPM_SCALE(200),
                       .SYNC_STAGES(3), .ADDR_WIDTH(11)) dut_s (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready_s), .prdata(prdata_s),
        .pslverr(pslverr_s), .tach(tach), .irq(irq_s));

    // Clock edges seen since reset released; a window end is the edge that makes this a multiple of GATE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) since_rst <= 0;
        else     since_rst <= since_rst + 1;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int ch = 0; ch < N; ch++)
            tach[ch] = (tach_per[ch] != 0) && ((cyc % tach_per[ch]) < (tach_per[ch] / 2));
    end

    task automatic xfer(input logic [10:0] a, input logic w, input logic [15:0] d,
                        output logic [15:0] rd, output logic [15:0] rd_s,
                        output logic er, output logic rdy);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(negedge clk); #1;
        penable = 1'b1;
        #1;
        rd = prdata; rd_s = prdata_s; er = pslverr; rdy = pready;
        @(negedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wait_cnt(input int s);
        int n = 0;
        while (since_rst != s && n < 5000) begin
            @(negedge clk); #1;
            n++;
        end
        if (since_rst != s) begin
            checks++; errors++;
            $display("FAIL wait_cnt: since_rst=%0d required=%0d", since_rst, s);
        end
    endtask

    function automatic int next_end();
        return (since_rst / GATE + 1) * GATE;
    endfunction

    task automatic test_reset();
        logic [15:0] rd, rs;
        logic er, rdy;
        exp_t e;
        logic [10:0] regs [10];
        regs = '{11'h000, 11'h002, 11'h010, 11'h012, 11'h014,
                 11'h016, 11'h018, 11'h01a, 11'h01c, 11'h01e};
        xfer(11'h002, 1'b1, 16'h000f, rd, rs, er, rdy);
        xfer(11'h012, 1'b1, 16'h1234, rd, rs, er, rdy);
        exp_q.push_back('{16'h000f, 1'b0, 1'b0, "pre_irq_en"});
        exp_q.push_back('{16'h1234, 1'b0, 1'b0, "pre_min0"});
        for (int i = 0; i < 2; i++) begin
            xfer(i == 0 ? 11'h002 : 11'h012, 1'b0, 16'h0, rd, rs, er, rdy);
            e = exp_q.pop_front();
            checks++;
            if ({rdy, er, rd} !== {1'b1, e.err, e.data}) begin
                errors++;
                $display("FAIL %s: rdy=%0b err=%0b data=%h required rdy=1 err=%0b data=%h",
                         e.name, rdy, er, rd, e.err, e.data);
            end
        end
        repeat (300) @(negedge clk);
        #1; rst = 1'b1; #2; rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back('{16'h0000, 1'b0, 1'b0, $sformatf("rst_reg_%03h", regs[i])});
            xfer(regs[i], 1'b0, 16'h0, rd, rs, er, rdy);
            e = exp_q.pop_front();
            checks++;
            if ({rdy, er, rd} !== {1'b1, e.err, e.data}) begin
                errors++;
                $display("FAIL %s: rdy=%0b err=%0b data=%h required rdy=1 err=%0b data=%h",
                         e.name, rdy, er, rd, e.err, e.data);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_irq: irq=%0b required 0", irq);
        end
        wait_cnt(998);
        exp_q.push_back('{16'h0000, 1'b0, 1'b0, "status_at_999"});
        xfer(11'h000, 1'b0, 16'h0, rd, rs, er, rdy);
        e = exp_q.pop_front();
        checks++;
        if ({rdy, er, rd} !== {1'b1, e.err, e.data}) begin
            errors++;
            $display("FAIL %s: rdy=%0b err=%0b data=%h required rdy=1 err=%0b data=%h",
                     e.name, rdy, er, rd, e.err, e.data);
        end
        rst = 1'b1; #2; rst = 1'b0;
        wait_cnt(999);
        exp_q.push_back('{16'h0f00, 1'b0, 1'b0, "status_at_1000"});
        xfer(11'h000, 1'b0, 16'h0, rd, rs, er, rdy);
        e = exp_q.pop_front();
        checks++;
        if ({rdy, er, rd} !== {1'b1, e.err, e.data}) begin
            errors++;
            $display("FAIL %s: rdy=%0b err=%0b data=%h required rdy=1 err=%0b data=%h",
                     e.name, rdy, er, rd, e.err, e.data);
        end
    endtask

    task automatic test_measure();
        logic [15:0] rd, rs;
        logic er, rdy;
        exp_t e;
        logic [10:0] addrs [5];
        addrs = '{11'h010, 11'h014, 11'h018, 11'h01c, 11'h000};
        tach_per[0] = 100;
        tach_per[1] = 50;
        wait_cnt(next_end() + GATE + 1);
        exp_q.push_back('{16'd300,  1'b0, 1'b0, "rpm0"});
        exp_q.push_back('{16'd600,  1'b0, 1'b0, "rpm1"});
        exp_q.push_back('{16'd0,    1'b0, 1'b0, "rpm2"});
        exp_q.push_back('{16'd0,    1'b0, 1'b0, "rpm3_idle"});
        exp_q.push_back('{16'h0f00, 1'b0, 1'b0, "status_valid"});
        for (int i = 0; i < 5; i++) begin
            xfer(addrs[i], 1'b0, 16'h0, rd, rs, er, rdy);
            e = exp_q.pop_front();
            checks++;
            if ({rdy, er, rd} !== {1'b1, e.err, e.data}) begin
                errors++;
                $display("FAIL %s: rdy=%0b err=%0b data=%h required rdy=1 err=%0b data=%h",
                         e.name, rdy, er, rd, e.err, e.data);
            end
        end
    endtask

    task automatic test_saturate();
        logic [15:0] rd, rs, v;
        logic er, rdy;
        exp_t e;
        logic [10:0] addrs [4];
        addrs = '{11'h01c, 11'h01c, 11'h010, 11'h014};
        tach_per[3] = 2;
        wait_cnt(next_end() + GATE + 1);
        exp_q.push_back('{16'd15000, 1'b0, 1'b0, "rpm3_scale30"});
        exp_q.push_back('{16'hffff,  1'b0, 1'b1, "rpm3_scale200_sat"});
        exp_q.push_back('{16'd2000,  1'b0, 1'b1, "rpm0_scale200"});
        exp_q.push_back('{16'd4000,  1'b0, 1'b1, "rpm1_scale200"});
        for (int i = 0; i < 4; i++) begin
            xfer(addrs[i], 1'b0, 16'h0, rd, rs, er, rdy);
            e = exp_q.pop_front();
            v = e.sel ? rs : rd;
            checks++;
            if ({rdy, er, v} !== {1'b1, e.err, e.data}) begin
                errors++;
                $display("FAIL %s: rdy=%0b err=%0b data=%h required rdy=1 err=%0b data=%h",
                         e.name, rdy, er, v, e.err, e.data);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] rd, rs;
        logic er, rdy;
        exp_t e;
        int we;
        xfer(11'h01a, 1'b1, 16'd100, rd, rs, er, rdy);
        xfer(11'h002, 1'b1, 16'h0004, rd, rs, er, rdy);
        we = next_end();
        wait_cnt(we);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL stall_irq_same_edge: irq=%0b required 0", irq);
        end
        @(negedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL stall_irq_next_clk: irq=%0b required 1", irq);
        end
        exp_q.push_back('{16'h0f04, 1'b0, 1'b0, "stall_status"});
        xfer(11'h000, 1'b0, 16'h0, rd, rs, er, rdy);
        e = exp_q.pop_front();
        checks++;
        if ({rdy, er, rd} !== {1'b1, e.err, e.data}) begin
            errors++;
            $display("FAIL %s: rdy=%0b err=%0b data=%h required rdy=1 err=%0b data=%h",
                     e.name, rdy, er, rd, e.err, e.data);
        end
        xfer(11'h000, 1'b1, 16'h0004, rd, rs, er, rdy);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL w1c_irq_hold: irq=%0b required 1", irq);
        end
        @(negedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_irq_fall: irq=%0b required 0", irq);
        end
        exp_q.push_back('{16'h0f00, 1'b0, 1'b0, "w1c_status"});
        xfer(11'h000, 1'b0, 16'h0, rd, rs, er, rdy);
        e = exp_q.pop_front();
        checks++;
        if ({rdy, er, rd} !== {1'b1, e.err, e.data}) begin
            errors++;
            $display("FAIL %s: rdy=%0b err=%0b data=%h required rdy=1 err=%0b data=%h",
                     e.name, rdy, er, rd, e.err, e.data);
        end
    endtask

    task automatic test_race();
        logic [15:0] rd, rs;
        logic er, rdy;
        exp_t e;
        int we;
        we = next_end();
        wait_cnt(we + 1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL race_irq_rearm: irq=%0b required 1", irq);
        end
        wait_cnt(we + GATE - 2);
        xfer(11'h000, 1'b1, 16'h0004, rd, rs, er, rdy);
        @(negedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL race_irq: irq=%0b required 1", irq);
        end
        exp_q.push_back('{16'h0f04, 1'b0, 1'b0, "race_status"});
        xfer(11'h000, 1'b0, 16'h0, rd, rs, er, rdy);
        e = exp_q.pop_front();
        checks++;
        if ({rdy, er, rd} !== {1'b1, e.err, e.data}) begin
            errors++;
            $display("FAIL %s: rdy=%0b err=%0b data=%h required rdy=1 err=%0b data=%h",
                     e.name, rdy, er, rd, e.err, e.data);
        end
    endtask

    task automatic test_bus_errors();
        logic [15:0] rd, rs;
        logic er, rdy;
        exp_t e;
        logic [10:0] addrs [5];
        addrs = '{11'h01c, 11'h020, 11'h004, 11'h010, 11'h01b};
        xfer(11'h010, 1'b1, 16'h5555, rd, rs, er, rdy);
        checks++;
        if ({rdy, er} !== 2'b11) begin
            errors++;
            $display("FAIL rpm_write_err: rdy=%0b err=%0b required rdy=1 err=1", rdy, er);
        end
        exp_q.push_back('{16'd15000, 1'b0, 1'b0, "rd_rpm3"});
        exp_q.push_back('{16'h0000,  1'b1, 1'b0, "rd_ch4_absent"});
        exp_q.push_back('{16'h0000,  1'b1, 1'b0, "rd_unmapped_004"});
        exp_q.push_back('{16'd300,   1'b0, 1'b0, "rpm0_unchanged"});
        exp_q.push_back('{16'd100,   1'b0, 1'b0, "min2_odd_addr"});
        for (int i = 0; i < 5; i++) begin
            xfer(addrs[i], 1'b0, 16'h0, rd, rs, er, rdy);
            e = exp_q.pop_front();
            checks++;
            if ({rdy, er, rd} !== {1'b1, e.err, e.data}) begin
                errors++;
                $display("FAIL %s: rdy=%0b err=%0b data=%h required rdy=1 err=%0b data=%h",
                         e.name, rdy, er, rd, e.err, e.data);
            end
        end
    endtask

    initial begin
        for (int ch = 0; ch < N; ch++) tach_per[ch] = 0;
        repeat (2) @(negedge clk);
        #1; rst = 1'b0;
        test_reset();
        test_measure();
        test_saturate();
        test_stall();
        test_race();
        test_bus_errors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
